// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the per-master address-phase bundle.
//   - HTRANS / HRESP encodings, HSIZE / HBURST enums
//   - ahb_addr_t: htrans, haddr, hwrite, hsize, hburst for one master.
//     haddr is carried at AHB_MAX_ADDR_W bits. Users zero-extend into it and
//     truncate back out of it, so any ADDR_W up to 64 fits.
package ahb_pkg;

  localparam int AHB_MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HSIZE_8    = 3'd0,
    HSIZE_16   = 3'd1,
    HSIZE_32   = 3'd2,
    HSIZE_64   = 3'd3,
    HSIZE_128  = 3'd4,
    HSIZE_256  = 3'd5,
    HSIZE_512  = 3'd6,
    HSIZE_1024 = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef struct packed {
    htrans_e                   htrans;
    logic [AHB_MAX_ADDR_W-1:0] haddr;
    logic                      hwrite;
    hsize_e                    hsize;
    hburst_e                   hburst;
  } ahb_addr_t;

endpackage

// File: rtl/ahb_phase_tracker.sv
// ahb_phase_tracker: address-phase and data-phase owner registers.
//   hclk, hresetn  : clock, async active-low reset
//   hreadyout_i    : slave HREADYOUT. Both phases advance only while it is high.
//   grant_any_i    : arbiter grant is non-zero
//   sel_master_i   : arbiter-selected master index
//   aph_req_i      : HTRANS[1] of the current address-phase owner
//   lock_hold_i    : suppress the ownership update (burst lock)
//   aph_valid_o / aph_owner_o, dph_valid_o / dph_owner_o : owner state
module ahb_phase_tracker #(
  parameter int MIDX_W = 2
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hreadyout_i,
  input  logic              grant_any_i,
  input  logic [MIDX_W-1:0] sel_master_i,
  input  logic              aph_req_i,
  input  logic              lock_hold_i,
  output logic              aph_valid_o,
  output logic [MIDX_W-1:0] aph_owner_o,
  output logic              dph_valid_o,
  output logic [MIDX_W-1:0] dph_owner_o
);

  logic              aph_valid_q, aph_valid_d;
  logic [MIDX_W-1:0] aph_owner_q, aph_owner_d;
  logic              dph_valid_q, dph_valid_d;
  logic [MIDX_W-1:0] dph_owner_q, dph_owner_d;

  always_comb begin
    aph_valid_d = aph_valid_q;
    aph_owner_d = aph_owner_q;
    dph_valid_d = dph_valid_q;
    dph_owner_d = dph_owner_q;
    if (hreadyout_i) begin
      // The transfer on the address bus is accepted now. It only produces
      // a data phase if the owner was actually issuing NONSEQ/SEQ.
      dph_valid_d = aph_valid_q && aph_req_i;
      dph_owner_d = aph_owner_q;
      if (!lock_hold_i) begin
        if (grant_any_i) begin
          aph_valid_d = 1'b1;
          aph_owner_d = sel_master_i;
        end else begin
          aph_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      aph_valid_q <= 1'b0;
      aph_owner_q <= '0;
      dph_valid_q <= 1'b0;
      dph_owner_q <= '0;
    end else begin
      aph_valid_q <= aph_valid_d;
      aph_owner_q <= aph_owner_d;
      dph_valid_q <= dph_valid_d;
      dph_owner_q <= dph_owner_d;
    end
  end

  assign aph_valid_o = aph_valid_q;
  assign aph_owner_o = aph_owner_q;
  assign dph_valid_o = dph_valid_q;
  assign dph_owner_o = dph_owner_q;

endmodule

// File: rtl/ahb_master_mux.sv
// ahb_master_mux: steers NUM_MASTERS AHB-Lite masters onto one slave port
// using the round-robin arbiter's registered grant.
//   m_*_i          : per-master address/control/write data
//   m_hready_o     : per-master HREADY. Non-owners requesting are stalled low.
//   m_hresp_o      : per-master HRESP. Only the data-phase owner sees the slave's.
//   m_hrdata_o     : slave read data broadcast
//   request_o      : to arbiter, HTRANS[1] of each master
//   grant_i, selected_master_i : from arbiter
//   s_*_o / s_*_i  : slave port. s_hready_o loops s_hreadyout_i back.
// Optional feature macro: AHB_MUX_BURST_LOCK_EN. When defined, the address-phase
// owner keeps the bus while it drives SEQ or BUSY, so bursts are never split.
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                                hclk,
  input  logic                                hresetn,
  input  logic [NUM_MASTERS-1:0][1:0]         m_htrans_i,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_haddr_i,
  input  logic [NUM_MASTERS-1:0]              m_hwrite_i,
  input  logic [NUM_MASTERS-1:0][2:0]         m_hsize_i,
  input  logic [NUM_MASTERS-1:0][2:0]         m_hburst_i,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_hwdata_i,
  output logic [NUM_MASTERS-1:0]              m_hready_o,
  output logic [NUM_MASTERS-1:0]              m_hresp_o,
  output logic [DATA_W-1:0]                   m_hrdata_o,
  output logic [NUM_MASTERS-1:0]              request_o,
  input  logic [NUM_MASTERS-1:0]              grant_i,
  input  logic [MIDX_W-1:0]                   selected_master_i,
  output logic                                s_hsel_o,
  output logic [1:0]                          s_htrans_o,
  output logic [ADDR_W-1:0]                   s_haddr_o,
  output logic                                s_hwrite_o,
  output logic [2:0]                          s_hsize_o,
  output logic [2:0]                          s_hburst_o,
  output logic [DATA_W-1:0]                   s_hwdata_o,
  output logic                                s_hready_o,
  input  logic                                s_hreadyout_i,
  input  logic                                s_hresp_i,
  input  logic [DATA_W-1:0]                   s_hrdata_i
);

  ahb_addr_t         m_addr [NUM_MASTERS];
  ahb_addr_t         sel_addr;
  logic              aph_valid, dph_valid, lock_hold;
  logic [MIDX_W-1:0] aph_owner, dph_owner;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    logic owns;

    assign m_addr[g] = '{htrans: htrans_e'(m_htrans_i[g]),
                         haddr:  AHB_MAX_ADDR_W'(m_haddr_i[g]),
                         hwrite: m_hwrite_i[g],
                         hsize:  hsize_e'(m_hsize_i[g]),
                         hburst: hburst_e'(m_hburst_i[g])};

    assign request_o[g] = m_htrans_i[g][1];

    // Owning either phase ties the master to the slave's ready. Otherwise
    // a requesting master holds its address until it wins the bus.
    assign owns = (aph_valid && aph_owner == MIDX_W'(g)) ||
                  (dph_valid && dph_owner == MIDX_W'(g));
    assign m_hready_o[g] = owns ? s_hreadyout_i : !m_htrans_i[g][1];
    assign m_hresp_o[g]  = (dph_valid && dph_owner == MIDX_W'(g)) ? s_hresp_i
                                                                  : HRESP_OKAY;
  end

`ifdef AHB_MUX_BURST_LOCK_EN
  assign lock_hold = aph_valid &&
                     (m_addr[aph_owner].htrans inside {HTRANS_SEQ, HTRANS_BUSY});
`else
  assign lock_hold = 1'b0;
`endif

  ahb_phase_tracker #(.MIDX_W(MIDX_W)) u_trk (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hreadyout_i (s_hreadyout_i),
    .grant_any_i (|grant_i),
    .sel_master_i(selected_master_i),
    .aph_req_i   (m_htrans_i[aph_owner][1]),
    .lock_hold_i (lock_hold),
    .aph_valid_o (aph_valid),
    .aph_owner_o (aph_owner),
    .dph_valid_o (dph_valid),
    .dph_owner_o (dph_owner)
  );

  // An all-zero bundle drives IDLE with zero address/control.
  assign sel_addr   = aph_valid ? m_addr[aph_owner] : '0;
  assign s_hsel_o   = aph_valid;
  assign s_htrans_o = sel_addr.htrans;
  assign s_haddr_o  = ADDR_W'(sel_addr.haddr);
  assign s_hwrite_o = sel_addr.hwrite;
  assign s_hsize_o  = sel_addr.hsize;
  assign s_hburst_o = sel_addr.hburst;

  assign s_hwdata_o = dph_valid ? m_hwdata_i[dph_owner] : '0;
  assign s_hready_o = s_hreadyout_i;
  assign m_hrdata_o = s_hrdata_i;

endmodule

// File: tb/tb_ahb_master_mux.sv
module tb_ahb_master_mux;
  localparam int NM = 4, AW = 32, DW = 32, MW = 2;

  logic                   hclk = 1'b0, hresetn;
  logic [NM-1:0][1:0]     m_htrans;
  logic [NM-1:0][AW-1:0]  m_haddr;
  logic [NM-1:0]          m_hwrite;
  logic [NM-1:0][2:0]     m_hsize, m_hburst;
  logic [NM-1:0][DW-1:0]  m_hwdata;
  logic [NM-1:0]          m_hready, m_hresp, request, grant;
  logic [DW-1:0]          m_hrdata, s_hwdata, s_hrdata;
  logic [MW-1:0]          sel;
  logic                   s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
  logic [1:0]             s_htrans;
  logic [AW-1:0]          s_haddr;
  logic [2:0]             s_hsize, s_hburst;

  ahb_master_mux #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m_htrans_i(m_htrans), .m_haddr_i(m_haddr), .m_hwrite_i(m_hwrite),
    .m_hsize_i(m_hsize), .m_hburst_i(m_hburst), .m_hwdata_i(m_hwdata),
    .m_hready_o(m_hready), .m_hresp_o(m_hresp), .m_hrdata_o(m_hrdata),
    .request_o(request), .grant_i(grant), .selected_master_i(sel),
    .s_hsel_o(s_hsel), .s_htrans_o(s_htrans), .s_haddr_o(s_haddr),
    .s_hwrite_o(s_hwrite), .s_hsize_o(s_hsize), .s_hburst_o(s_hburst),
    .s_hwdata_o(s_hwdata), .s_hready_o(s_hready),
    .s_hreadyout_i(s_hreadyout), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata)
  );

  always #5 hclk = ~hclk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which master (or -1 for nobody) holds each phase.
  int aph_m = -1, dph_m = -1;

  function automatic bit locked();
`ifdef AHB_MUX_BURST_LOCK_EN
    return aph_m >= 0 && (m_htrans[aph_m] == 2'b11 || m_htrans[aph_m] == 2'b01);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      aph_m <= -1;
      dph_m <= -1;
    end else if (s_hreadyout) begin
      dph_m <= (aph_m >= 0 && m_htrans[aph_m][1]) ? aph_m : -1;
      if (!locked()) aph_m <= (grant != 0) ? int'(sel) : -1;
    end
  end

  // Compare process: every negedge, all outputs against the model.
  logic [NM-1:0] e_rdy, e_resp;
  always @(negedge hclk) if (chk_en) begin
    for (int i = 0; i < NM; i++) begin
      e_rdy[i]  = (i == aph_m || i == dph_m) ? s_hreadyout : !m_htrans[i][1];
      e_resp[i] = (i == dph_m) ? s_hresp : 1'b0;
    end
    chk("m_hready", m_hready, e_rdy);
    chk("m_hresp", m_hresp, e_resp);
    chk("request", request, {m_htrans[3][1], m_htrans[2][1], m_htrans[1][1], m_htrans[0][1]});
    chk("m_hrdata", m_hrdata, s_hrdata);
    chk("s_hready", s_hready, s_hreadyout);
    chk("s_hsel", s_hsel, aph_m >= 0);
    chk("s_htrans", s_htrans, aph_m >= 0 ? m_htrans[aph_m] : 2'b00);
    chk("s_haddr", s_haddr, aph_m >= 0 ? m_haddr[aph_m] : '0);
    chk("s_hwrite", s_hwrite, aph_m >= 0 ? m_hwrite[aph_m] : 1'b0);
    chk("s_hsize", s_hsize, aph_m >= 0 ? m_hsize[aph_m] : 3'd0);
    chk("s_hburst", s_hburst, aph_m >= 0 ? m_hburst[aph_m] : 3'd0);
    chk("s_hwdata", s_hwdata, dph_m >= 0 ? m_hwdata[dph_m] : '0);
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_all();
    m_htrans = '0; grant = '0; sel = '0; s_hreadyout = 1'b1; s_hresp = 1'b0;
  endtask

  task automatic drain();
    idle_all();
    step(); step();
  endtask

  initial begin
    hresetn = 1'b0;
    idle_all();
    m_haddr = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0; m_hwdata = '0;
    s_hrdata = '0;
    m_htrans[0] = 2'b10;
    #2;
    chk_en = 1;
    chk("rst s_htrans", s_htrans, 2'b00);
    chk("rst s_hsel", s_hsel, 1'b0);
    chk("rst m_hready", m_hready, 4'b1110);
    chk("rst m_hresp", m_hresp, 4'b0000);
    step(); step();
    hresetn = 1'b1;
    idle_all();
    step();

    // Single write from master 2.
    m_htrans[2] = 2'b10; m_haddr[2] = 32'h100; m_hwrite[2] = 1'b1;
    #1;
    chk("sw request", request, 4'b0100);
    chk("sw stall", m_hready[2], 1'b0);
    grant = 4'b0100; sel = 2'd2;
    step();
    chk("sw s_haddr", s_haddr, 32'h100);
    chk("sw s_hsel", s_hsel, 1'b1);
    chk("sw model aph", aph_m, 2);
    step();
    m_htrans[2] = 2'b00; m_hwdata[2] = 32'hA5A5_A5A5; grant = '0;
    #1;
    chk("sw s_hwdata", s_hwdata, 32'hA5A5_A5A5);
    chk("sw m_hready", m_hready[2], 1'b1);
    step();
    chk("sw done hwdata", s_hwdata, 32'h0);
    chk("sw done hsel", s_hsel, 1'b0);
    drain();

    // Contention: masters 1 and 3, grant 3 then 1.
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h111;
    m_htrans[3] = 2'b10; m_haddr[3] = 32'h333;
    grant = 4'b1000; sel = 2'd3;
    step();
    chk("ct s_haddr3", s_haddr, 32'h333);
    chk("ct stall1", m_hready[1], 1'b0);
    grant = 4'b0010; sel = 2'd1;
    step();
    m_htrans[3] = 2'b00;
    #1;
    chk("ct s_haddr1", s_haddr, 32'h111);
    chk("ct ready1", m_hready[1], 1'b1);
    drain();

    // Wait states with grant moving to master 0 mid-stall.
    m_htrans[3] = 2'b10; m_haddr[3] = 32'h300; m_hwrite[3] = 1'b1;
    grant = 4'b1000; sel = 2'd3;
    step(); step();
    m_htrans[3] = 2'b00; m_hwdata[3] = 32'h1234_5678;
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h0AA0;
    grant = 4'b0001; sel = 2'd0; s_hreadyout = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ws s_hwdata", s_hwdata, 32'h1234_5678);
      chk("ws s_haddr", s_haddr, 32'h300);
      chk("ws stall0", m_hready[0], 1'b0);
      step();
    end
    s_hreadyout = 1'b1;
    step();
    chk("ws new owner", s_haddr, 32'h0AA0);
    chk("ws model aph", aph_m, 0);
    drain();

    // Two-cycle ERROR to master 1.
    m_htrans[1] = 2'b10; grant = 4'b0010; sel = 2'd1;
    step(); step();
    m_htrans[1] = 2'b00; grant = '0; s_hreadyout = 1'b0; s_hresp = 1'b1;
    #1;
    chk("er cyc1 hresp", m_hresp, 4'b0010);
    chk("er cyc1 ready", m_hready[1], 1'b0);
    step();
    s_hreadyout = 1'b1;
    #1;
    chk("er cyc2 hresp", m_hresp, 4'b0010);
    chk("er cyc2 ready", m_hready[1], 1'b1);
    step();
    s_hresp = 1'b0;
    drain();

    // INCR4 burst from master 0, grant moves to master 2 after beat 2.
    m_hburst[0] = 3'd3;
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h200;
    m_htrans[2] = 2'b10; m_haddr[2] = 32'h400;
    grant = 4'b0001; sel = 2'd0;
    step();
    chk("bl beat1", s_haddr, 32'h200);
    step();
    m_htrans[0] = 2'b11; m_haddr[0] = 32'h204;
    step();
    m_haddr[0] = 32'h208; grant = 4'b0100; sel = 2'd2;
    #1;
    chk("bl beat3", s_haddr, 32'h208);
    step();
    m_haddr[0] = 32'h20C;
    #1;
`ifdef AHB_MUX_BURST_LOCK_EN
    chk("bl beat4", s_haddr, 32'h20C);
    step();
    m_htrans[0] = 2'b00;
    #1;
    chk("bl still 0", s_haddr, 32'h20C);
    step();
    chk("bl then 2", s_haddr, 32'h400);
`else
    chk("bl split", s_haddr, 32'h400);
    chk("bl split htrans", s_htrans, 2'b10);
`endif
    m_hburst[0] = 3'd0;
    drain();

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 2000; n++) begin
      step();
      for (int i = 0; i < NM; i++) begin
        m_htrans[i] = 2'($urandom_range(3));
        m_haddr[i]  = $urandom;
        m_hwrite[i] = 1'($urandom_range(1));
        m_hsize[i]  = 3'($urandom_range(7));
        m_hburst[i] = 3'($urandom_range(7));
        m_hwdata[i] = $urandom;
      end
      sel = 2'($urandom_range(NM - 1));
      grant = ($urandom_range(3) == 0) ? 4'b0000 : 4'(1 << sel);
      s_hreadyout = ($urandom_range(3) != 0);
      s_hresp = 1'($urandom_range(1));
      s_hrdata = $urandom;
      hresetn = ($urandom_range(99) != 0);
    end
    hresetn = 1'b1;
    drain();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
